// File: rtl/rv32_hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// rv32_hazard_scoreboard_if
// Bundles the decode-side signals of the in-order hazard scoreboard.
//
// Parameters:
//   NUM_READ   - register-file read ports checked per instruction
//   NUM_STAGES - tracked stages after decode
//   SEL_W      - width of latency and bypass-select fields
//
// Signals (direction seen from the scoreboard, i.e. the slave modport):
//   stop        in   pipeline freeze; slots hold, no issue accepted
//   flush       in   kill the instruction entering slot 1, invalidate slot 1
//   issue_valid in   decode holds a real instruction
//   issue_wr    in   instruction writes rd
//   issue_rd    in   destination register
//   issue_lat   in   first slot index at which the result is forwardable
//   use_rs      in   per port: port reads a register
//   rs_addr     in   per port source register, port i at [5i+4:5i]
//   stall       out  decode must hold and inject a bubble
//   bypass_sel  out  per port: 0 = register file, k = forward from slot k
//   stall_count  out (only with RV32_SB_STATS_EN) saturating stall cycles
//   bypass_count out (only with RV32_SB_STATS_EN) saturating bypassed issues
// -----------------------------------------------------------------------------
interface rv32_hazard_scoreboard_if #(
  parameter int NUM_READ   = 3,
  parameter int NUM_STAGES = 3,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
);

  logic                      stop;
  logic                      flush;
  logic                      issue_valid;
  logic                      issue_wr;
  logic [4:0]                issue_rd;
  logic [SEL_W-1:0]          issue_lat;
  logic [NUM_READ-1:0]       use_rs;
  logic [NUM_READ*5-1:0]     rs_addr;
  logic                      stall;
  logic [NUM_READ*SEL_W-1:0] bypass_sel;
`ifdef RV32_SB_STATS_EN
  logic [31:0]               stall_count;
  logic [31:0]               bypass_count;
`else
  // statistics outputs are not present in this build
`endif

  // Decoder side: drives the instruction, receives stall and bypass select.
  modport master (
    output stop, flush, issue_valid, issue_wr, issue_rd, issue_lat, use_rs, rs_addr,
    input  stall, bypass_sel
`ifdef RV32_SB_STATS_EN
    , input stall_count, bypass_count
`else
`endif
  );

  // Scoreboard side.
  modport slave (
    input  stop, flush, issue_valid, issue_wr, issue_rd, issue_lat, use_rs, rs_addr,
    output stall, bypass_sel
`ifdef RV32_SB_STATS_EN
    , output stall_count, bypass_count
`else
`endif
  );

endinterface

// File: rtl/rv32_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// rv32_hazard_scoreboard
// In-order hazard scoreboard for the decode stage. One slot per downstream
// stage records {valid, rd, lat} of the instruction in that stage. Each cycle
// the decode-stage source registers are compared against every slot to produce
// a stall request and a per-port bypass source select (combinational).
//
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-high reset, clears all slots
//   sb     rv32_hazard_scoreboard_if.slave (issue, lookup, stall, bypass_sel)
//
// Optional feature: define RV32_SB_STATS_EN to add saturating 32-bit
// stall_count and bypass_count outputs on the interface.
// -----------------------------------------------------------------------------
module rv32_hazard_scoreboard #(
  parameter int NUM_READ   = 3,
  parameter int NUM_STAGES = 3,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input logic                     clk,
  input logic                     reset,
  rv32_hazard_scoreboard_if.slave sb
);

  localparam logic [SEL_W-1:0] MAX_LAT = SEL_W'(NUM_STAGES);
  localparam logic [SEL_W-1:0] MIN_LAT = SEL_W'(1);

  // Slot state; index 1 is the decode/exec buffer, NUM_STAGES the last stage.
  logic [NUM_STAGES:1] valid_q, valid_d;
  logic [4:0]          rd_q  [1:NUM_STAGES];
  logic [4:0]          rd_d  [1:NUM_STAGES];
  logic [SEL_W-1:0]    lat_q [1:NUM_STAGES];
  logic [SEL_W-1:0]    lat_d [1:NUM_STAGES];

  // Lookup results.
  logic [NUM_READ-1:0]       port_active_s;
  logic [NUM_READ-1:0]       match_found_s;
  logic [NUM_READ-1:0]       port_stall_s;
  logic [SEL_W-1:0]          match_slot_s [NUM_READ];
  logic [SEL_W-1:0]          match_lat_s  [NUM_READ];
  logic [NUM_READ*SEL_W-1:0] bypass_sel_s;
  logic                      stall_s;

  // Issue path.
  logic [SEL_W-1:0] lat_clamp_s;
  logic             accept_s;
  logic             new_valid_s;

  // Per-port search for the youngest slot that writes the source register.
  always_comb begin
    port_active_s = {NUM_READ{1'b0}};
    match_found_s = {NUM_READ{1'b0}};
    for (int i = 0; i < NUM_READ; i++) begin
      match_slot_s[i]  = {SEL_W{1'b0}};
      match_lat_s[i]   = {SEL_W{1'b0}};
      port_active_s[i] = sb.use_rs[i] && (sb.rs_addr[i*5 +: 5] != 5'd0);
      // Walk from oldest to youngest so the last hit is the youngest writer.
      for (int k = NUM_STAGES; k >= 1; k--) begin
        if (valid_q[k] && (rd_q[k] == sb.rs_addr[i*5 +: 5])) begin
          match_found_s[i] = 1'b1;
          match_slot_s[i]  = SEL_W'(k);
          match_lat_s[i]   = lat_q[k];
        end else begin
          match_found_s[i] = match_found_s[i];
        end
      end
    end
  end

  // Forward when the youngest writer's result exists at its slot, else stall;
  // an older ready writer must not be used because its value is stale.
  always_comb begin
    bypass_sel_s = {(NUM_READ*SEL_W){1'b0}};
    port_stall_s = {NUM_READ{1'b0}};
    for (int i = 0; i < NUM_READ; i++) begin
      if (port_active_s[i] && match_found_s[i]) begin
        if (match_slot_s[i] >= match_lat_s[i]) begin
          bypass_sel_s[i*SEL_W +: SEL_W] = match_slot_s[i];
        end else begin
          port_stall_s[i] = 1'b1;
        end
      end else begin
        port_stall_s[i] = 1'b0;
      end
    end
    stall_s = |port_stall_s;
  end

  // Latency clamp and issue acceptance.
  always_comb begin
    if (sb.issue_lat == {SEL_W{1'b0}}) begin
      lat_clamp_s = MIN_LAT;
    end else if (sb.issue_lat >= MAX_LAT) begin
      lat_clamp_s = MAX_LAT;
    end else begin
      lat_clamp_s = sb.issue_lat;
    end
    accept_s    = sb.issue_valid & ~stall_s & ~sb.stop & ~sb.flush;
    // x0 is never a hazard, so writers to it enter as bubbles.
    new_valid_s = accept_s & sb.issue_wr & (sb.issue_rd != 5'd0);
  end

  // Slot shift register next state: advance unless frozen, flush kills slot 1.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    lat_d   = lat_q;
    if (!sb.stop) begin
      for (int k = NUM_STAGES; k >= 2; k--) begin
        // A flushed slot 1 moves on as a bubble.
        valid_d[k] = (k == 2) ? (valid_q[k-1] & ~sb.flush) : valid_q[k-1];
        rd_d[k]    = rd_q[k-1];
        lat_d[k]   = lat_q[k-1];
      end
      valid_d[1] = new_valid_s;
      rd_d[1]    = sb.issue_rd;
      lat_d[1]   = lat_clamp_s;
    end else begin
      if (sb.flush) begin
        valid_d[1] = 1'b0;
      end else begin
        valid_d[1] = valid_q[1];
      end
    end
  end

  // Slot registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= {NUM_STAGES{1'b0}};
      for (int k = 1; k <= NUM_STAGES; k++) begin
        rd_q[k]  <= 5'd0;
        lat_q[k] <= {SEL_W{1'b0}};
      end
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      lat_q   <= lat_d;
    end
  end

  assign sb.stall      = stall_s;
  assign sb.bypass_sel = bypass_sel_s;

`ifdef RV32_SB_STATS_EN
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] bypass_count_q, bypass_count_d;

  // Saturating statistics counters next state.
  always_comb begin
    if (stall_s && !sb.stop && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
    if (accept_s && (bypass_sel_s != {(NUM_READ*SEL_W){1'b0}}) &&
        (bypass_count_q != 32'hFFFF_FFFF)) begin
      bypass_count_d = bypass_count_q + 32'd1;
    end else begin
      bypass_count_d = bypass_count_q;
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q  <= 32'd0;
      bypass_count_q <= 32'd0;
    end else begin
      stall_count_q  <= stall_count_d;
      bypass_count_q <= bypass_count_d;
    end
  end

  assign sb.stall_count  = stall_count_q;
  assign sb.bypass_count = bypass_count_q;
`else
  // no statistics counters in this build
`endif

endmodule

// File: tb/tb_rv32_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_rv32_hazard_scoreboard
// Self-checking bench for rv32_hazard_scoreboard (NUM_READ=3, NUM_STAGES=3).
// Each scenario task drives a table of per-cycle vectors, pushes the expected
// {stall, bypass_sel} into a scoreboard queue, and pops/compares it at the
// following falling edge. Inputs change 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_rv32_hazard_scoreboard;

  localparam int NR = 3;
  localparam int NS = 3;
  localparam int SW = 2;

  logic clk;
  logic reset;

  rv32_hazard_scoreboard_if #(.NUM_READ(NR), .NUM_STAGES(NS), .SEL_W(SW)) sb_if ();

  rv32_hazard_scoreboard #(.NUM_READ(NR), .NUM_STAGES(NS), .SEL_W(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        iv;
    logic        iw;
    logic [4:0]  rd;
    logic [1:0]  lat;
    logic [2:0]  use_rs;
    logic [14:0] rs;
    logic        stop;
    logic        flush;
    logic        e_stall;
    logic [5:0]  e_sel;
    logic        chk;
  } vec_t;

  typedef struct {
    logic       stall;
    logic [5:0] sel;
    logic       chk;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(int iv, int iw, int rd, int lat, int u,
                              int a0, int a1, int a2, int st, int fl,
                              int es, int esel, int cs);
    vec_t v;
    v.iv      = 1'(iv);
    v.iw      = 1'(iw);
    v.rd      = 5'(rd);
    v.lat     = 2'(lat);
    v.use_rs  = 3'(u);
    v.rs      = {5'(a2), 5'(a1), 5'(a0)};
    v.stop    = 1'(st);
    v.flush   = 1'(fl);
    v.e_stall = 1'(es);
    v.e_sel   = 6'(esel);
    v.chk     = 1'(cs);
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  task automatic apply(input vec_t v);
    sb_if.issue_valid = v.iv;
    sb_if.issue_wr    = v.iw;
    sb_if.issue_rd    = v.rd;
    sb_if.issue_lat   = v.lat;
    sb_if.use_rs      = v.use_rs;
    sb_if.rs_addr     = v.rs;
    sb_if.stop        = v.stop;
    sb_if.flush       = v.flush;
  endtask

  task automatic test_reset();
    exp_t e;
    apply(mk(1, 1, 5, 1, 'b111, 5, 5, 5, 0, 0, 0, 0, 1));
    reset = 1'b1;
    repeat (2) begin
      exp_q.push_back('{1'b0, 6'd0, 1'b1});
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if (sb_if.stall !== e.stall || sb_if.bypass_sel !== e.sel) begin
        n_err++;
        $display("FAIL reset_state: stall=%b bypass_sel=%b, expected stall=%b bypass_sel=%b",
                 sb_if.stall, sb_if.bypass_sel, e.stall, e.sel);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    apply(mk(0, 0, 0, 1, 'b111, 5, 5, 5, 0, 0, 0, 0, 1));
    exp_q.push_back('{1'b0, 6'd0, 1'b1});
    @(negedge clk);
    e = exp_q.pop_front();
    n_vec++;
    if (sb_if.stall !== e.stall || sb_if.bypass_sel !== e.sel) begin
      n_err++;
      $display("FAIL post_reset_empty: stall=%b bypass_sel=%b, expected stall=%b bypass_sel=%b",
               sb_if.stall, sb_if.bypass_sel, e.stall, e.sel);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alu_forward();
    vec_t v[$];
    exp_t e;
    v.push_back(mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 0, 1, 'b001, 5, 0, 0, 0, 0, 0, 'b01, 1));
    v.push_back(mk(0, 0, 0, 1, 'b001, 5, 0, 0, 0, 0, 0, 'b10, 1));
    v.push_back(mk(0, 0, 0, 1, 'b001, 5, 0, 0, 0, 0, 0, 'b11, 1));
    v.push_back(mk(0, 0, 0, 1, 'b001, 5, 0, 0, 0, 0, 0, 0, 1));
    foreach (v[j]) begin
      apply(v[j]);
      exp_q.push_back('{v[j].e_stall, v[j].e_sel, v[j].chk});
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if (sb_if.stall !== e.stall || (e.chk && sb_if.bypass_sel !== e.sel)) begin
        n_err++;
        $display("FAIL alu_forward[%0d]: stall=%b bypass_sel=%b, expected stall=%b bypass_sel=%b",
                 j, sb_if.stall, sb_if.bypass_sel, e.stall, e.sel);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    exp_t e;
    v.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(1, 1, 2, 1, 'b001, 1, 0, 0, 0, 0, 0, 'b01, 1));
    v.push_back(mk(0, 0, 0, 1, 'b011, 1, 2, 0, 0, 0, 0, 'b00_01_10, 1));
    v.push_back(mk(0, 0, 0, 1, 'b011, 1, 2, 0, 0, 0, 0, 'b00_10_11, 1));
    v.push_back(mk(0, 0, 0, 1, 'b011, 1, 2, 0, 0, 0, 0, 'b00_11_00, 1));
    v.push_back(mk(0, 0, 0, 1, 'b011, 1, 2, 0, 0, 0, 0, 0, 1));
    foreach (v[j]) begin
      apply(v[j]);
      exp_q.push_back('{v[j].e_stall, v[j].e_sel, v[j].chk});
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if (sb_if.stall !== e.stall || (e.chk && sb_if.bypass_sel !== e.sel)) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: stall=%b bypass_sel=%b, expected stall=%b bypass_sel=%b",
                 j, sb_if.stall, sb_if.bypass_sel, e.stall, e.sel);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    vec_t v[$];
    exp_t e;
    v.push_back(mk(1, 1, 7, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(1, 0, 0, 1, 'b001, 7, 0, 0, 0, 0, 1, 0, 0));
    v.push_back(mk(1, 0, 0, 1, 'b001, 7, 0, 0, 0, 0, 0, 'b10, 1));
    repeat (3) v.push_back(idle());
    foreach (v[j]) begin
      apply(v[j]);
      exp_q.push_back('{v[j].e_stall, v[j].e_sel, v[j].chk});
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if (sb_if.stall !== e.stall || (e.chk && sb_if.bypass_sel !== e.sel)) begin
        n_err++;
        $display("FAIL load_use[%0d]: stall=%b bypass_sel=%b, expected stall=%b bypass_sel=%b",
                 j, sb_if.stall, sb_if.bypass_sel, e.stall, e.sel);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_younger_writer();
    vec_t v[$];
    exp_t e;
    v.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(1, 1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(1, 0, 0, 1, 'b001, 3, 0, 0, 0, 0, 1, 0, 0));
    v.push_back(mk(1, 0, 0, 1, 'b001, 3, 0, 0, 0, 0, 1, 0, 0));
    v.push_back(mk(1, 0, 0, 1, 'b001, 3, 0, 0, 0, 0, 0, 'b11, 1));
    repeat (3) v.push_back(idle());
    foreach (v[j]) begin
      apply(v[j]);
      exp_q.push_back('{v[j].e_stall, v[j].e_sel, v[j].chk});
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if (sb_if.stall !== e.stall || (e.chk && sb_if.bypass_sel !== e.sel)) begin
        n_err++;
        $display("FAIL younger_writer[%0d]: stall=%b bypass_sel=%b, expected stall=%b bypass_sel=%b",
                 j, sb_if.stall, sb_if.bypass_sel, e.stall, e.sel);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stop_flush();
    vec_t v[$];
    exp_t e;
    v.push_back(mk(1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // Frozen: x9 stays in slot 1 and the x10 issue is not accepted.
    repeat (4) v.push_back(mk(1, 1, 10, 1, 'b001, 9, 0, 0, 1, 0, 0, 'b01, 1));
    // Flush while frozen: slot 1 still visible this cycle, cleared at the edge.
    v.push_back(mk(1, 1, 10, 1, 'b001, 9, 0, 0, 1, 1, 0, 'b01, 1));
    v.push_back(mk(0, 0, 0, 1, 'b011, 9, 10, 0, 0, 0, 0, 0, 1));
    // Flush while running: x11 must not reach slot 2, x12 is not accepted.
    v.push_back(mk(1, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(1, 1, 12, 1, 'b001, 11, 0, 0, 0, 1, 0, 'b01, 1));
    v.push_back(mk(0, 0, 0, 1, 'b011, 11, 12, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 0, 1, 'b011, 11, 12, 0, 0, 0, 0, 0, 1));
    foreach (v[j]) begin
      apply(v[j]);
      exp_q.push_back('{v[j].e_stall, v[j].e_sel, v[j].chk});
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if (sb_if.stall !== e.stall || (e.chk && sb_if.bypass_sel !== e.sel)) begin
        n_err++;
        $display("FAIL stop_flush[%0d]: stall=%b bypass_sel=%b, expected stall=%b bypass_sel=%b",
                 j, sb_if.stall, sb_if.bypass_sel, e.stall, e.sel);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_multiport();
    vec_t v[$];
    exp_t e;
    v.push_back(mk(1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 0, 1, 'b111, 6, 4, 20, 0, 0, 0, 'b00_10_01, 1));
    v.push_back(mk(0, 0, 0, 1, 'b111, 6, 4, 20, 0, 0, 0, 'b00_11_10, 1));
    v.push_back(mk(0, 0, 0, 1, 'b111, 6, 4, 20, 0, 0, 0, 'b00_00_11, 1));
    v.push_back(mk(0, 0, 0, 1, 'b111, 6, 4, 20, 0, 0, 0, 0, 1));
    foreach (v[j]) begin
      apply(v[j]);
      exp_q.push_back('{v[j].e_stall, v[j].e_sel, v[j].chk});
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if (sb_if.stall !== e.stall || (e.chk && sb_if.bypass_sel !== e.sel)) begin
        n_err++;
        $display("FAIL multiport[%0d]: stall=%b bypass_sel=%b, expected stall=%b bypass_sel=%b",
                 j, sb_if.stall, sb_if.bypass_sel, e.stall, e.sel);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_and_reset();
    vec_t v[$];
    exp_t e;
    v.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 0, 1, 'b111, 0, 0, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(1, 1, 13, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 0, 1, 'b110, 13, 0, 5, 0, 0, 0, 0, 1));
    foreach (v[j]) begin
      apply(v[j]);
      exp_q.push_back('{v[j].e_stall, v[j].e_sel, v[j].chk});
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if (sb_if.stall !== e.stall || (e.chk && sb_if.bypass_sel !== e.sel)) begin
        n_err++;
        $display("FAIL zero_disabled[%0d]: stall=%b bypass_sel=%b, expected stall=%b bypass_sel=%b",
                 j, sb_if.stall, sb_if.bypass_sel, e.stall, e.sel);
      end
      @(posedge clk); #1;
    end
    // x13 (lat 3) now sits in slot 2: reading it stalls until reset hits.
    apply(mk(0, 0, 0, 1, 'b001, 13, 0, 0, 0, 0, 0, 0, 1));
    #2;
    exp_q.push_back('{1'b1, 6'd0, 1'b0});
    e = exp_q.pop_front();
    n_vec++;
    if (sb_if.stall !== e.stall) begin
      n_err++;
      $display("FAIL pre_reset_stall: stall=%b, expected stall=%b", sb_if.stall, e.stall);
    end
    reset = 1'b1;
    #1;
    exp_q.push_back('{1'b0, 6'd0, 1'b1});
    e = exp_q.pop_front();
    n_vec++;
    if (sb_if.stall !== e.stall || sb_if.bypass_sel !== e.sel) begin
      n_err++;
      $display("FAIL async_reset_drop: stall=%b bypass_sel=%b, expected stall=%b bypass_sel=%b",
               sb_if.stall, sb_if.bypass_sel, e.stall, e.sel);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.push_back('{1'b0, 6'd0, 1'b1});
    @(negedge clk);
    e = exp_q.pop_front();
    n_vec++;
    if (sb_if.stall !== e.stall || sb_if.bypass_sel !== e.sel) begin
      n_err++;
      $display("FAIL after_reset_release: stall=%b bypass_sel=%b, expected stall=%b bypass_sel=%b",
               sb_if.stall, sb_if.bypass_sel, e.stall, e.sel);
    end
    @(posedge clk); #1;
    apply(idle());
  endtask

`ifdef RV32_SB_STATS_EN
  task automatic test_stats();
    vec_t v[$];
    exp_t e;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_vec++;
    if (sb_if.stall_count !== 32'd0 || sb_if.bypass_count !== 32'd0) begin
      n_err++;
      $display("FAIL stats_reset: stall_count=%0d bypass_count=%0d, expected 0 and 0",
               sb_if.stall_count, sb_if.bypass_count);
    end
    for (int p = 0; p < 3; p++) begin
      v.push_back(mk(1, 1, 14 + p, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      v.push_back(mk(1, 0, 0, 1, 'b001, 14 + p, 0, 0, 0, 0, 1, 0, 0));
      v.push_back(mk(1, 0, 0, 1, 'b001, 14 + p, 0, 0, 0, 0, 0, 'b10, 1));
      repeat (3) v.push_back(idle());
    end
    foreach (v[j]) begin
      apply(v[j]);
      exp_q.push_back('{v[j].e_stall, v[j].e_sel, v[j].chk});
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if (sb_if.stall !== e.stall || (e.chk && sb_if.bypass_sel !== e.sel)) begin
        n_err++;
        $display("FAIL stats_pairs[%0d]: stall=%b bypass_sel=%b, expected stall=%b bypass_sel=%b",
                 j, sb_if.stall, sb_if.bypass_sel, e.stall, e.sel);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (sb_if.stall_count !== 32'd3 || sb_if.bypass_count !== 32'd3) begin
      n_err++;
      $display("FAIL stats_counts: stall_count=%0d bypass_count=%0d, expected 3 and 3",
               sb_if.stall_count, sb_if.bypass_count);
    end
  endtask
`else
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    apply(idle());
    test_reset();
    test_alu_forward();
    test_back_to_back();
    test_load_use();
    test_younger_writer();
    test_stop_flush();
    test_multiport();
    test_zero_and_reset();
`ifdef RV32_SB_STATS_EN
    test_stats();
`else
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
